inv_output_sequencer: RTL and testbench
=======================================

# inv_output_sequencer

Per-channel start/stop and fault-recovery sequencer for one inverter output bridge (instantiated twice, channel 1 and 2). It orders bypass SCR, output relay and bridge PWM enable on start and stop, kills PWM on any filtered protection flag, and performs bounded auto-retry before latching a lockout. Its outputs are the PWM gate-enable term for the bridge high sides and the relay/SCR drive commands.

## Interface
- SCR_LEAD_CYC, 50000: SCR-on time before the relay command (1 ms at 50 MHz).
- RLY_SETTLE_CYC, 500000: relay settle time before PWM enable (10 ms).
- SCR_HOLD_CYC, 250000: SCR hold time after relay opens on stop (5 ms).
- RETRY_CYC, 5000000: dead time after a fault before a retry (100 ms).
- RETRY_CLR_CYC, 50000000: continuous RUN time that clears the retry count (1 s).
- MAX_RETRY, 3: number of faults that causes lockout (1..7).
- CNT_W, 26: shared timer width; every *_CYC must be < 2^CNT_W and ≥ 1.
- CLK_50M  in  1  system clock, 50 MHz.
- Rst  in  1  synchronous, active-high reset.
- Run_Req  in  1  DSP run command, level.
- Reset_D  in  1  DSP fault-clear; acts on its rising edge.
- InvOcp_F  in  1  filtered inverter overcurrent, active-low (0 = fault).
- OP_Ovp_F  in  1  filtered output overvoltage, active-low.
- BusOvp_F  in  1  filtered bus overvoltage, active-low.
- Pwm_En  out  1  high-side PWM enable.
- OP_Rly_C  out  1  output relay drive.
- OP_Scr_C  out  1  bypass SCR drive.
- Fault_Code  out  3  latched fault: bit0 Ocp, bit1 Ovp, bit2 BusOvp.
- Retry_Cnt  out  3  faults since the last clear.
- Lockout  out  1  latched lockout.
- State  out  3  current state encoding, for debug.

## Operation
- All outputs are registered. Reset value of every output is 0. State resets to OFF.
- A fault is present when any active-low flag is 0.
- States and exits:
  - OFF: all drives 0. Exits to SCR_LEAD when Run_Req=1 and no fault is present. A fault in OFF blocks the start but is not counted or latched.
  - SCR_LEAD: Scr=1. Exits to RLY_SETTLE after SCR_LEAD_CYC.
  - RLY_SETTLE: Scr=1, Rly=1. Exits to RUN after RLY_SETTLE_CYC.
  - RUN: Rly=1, Pwm_En=1, Scr=0. Once RUN has been held for RETRY_CLR_CYC, Retry_Cnt is cleared to 0.
  - STOP: entered from SCR_LEAD, RLY_SETTLE or RUN when Run_Req=0. Pwm_En=0, Rly=0, Scr=1. Exits to OFF after SCR_HOLD_CYC. Run_Req returning high during STOP does not abort STOP.
  - FAULT: entered from SCR_LEAD, RLY_SETTLE, RUN or STOP when a fault is present. All drives 0. On entry, Fault_Code latches the active-fault vector and Retry_Cnt increments. If the new count ≥ MAX_RETRY, the next state is LOCKOUT instead. After RETRY_CYC: if no fault is present and Run_Req=1, go to SCR_LEAD; otherwise go to OFF.
  - LOCKOUT: all drives 0, Lockout=1. Leaves only on a Reset_D rising edge, then goes to OFF.
- Reset_D rising edge, in any state: clears Fault_Code and Retry_Cnt; in LOCKOUT, also clears Lockout and goes to OFF.
- Simultaneous fault and Reset_D edge: the fault wins. The code latches and Retry_Cnt becomes 1.
- Fault and Run_Req falling in the same cycle: FAULT wins over STOP.
- Retry_Cnt saturates at 7.
- One shared CNT_W down-counter is loaded with (param−1) on each state entry; state exit occurs on the cycle after it reads 0.

## Timing
- Fault flag sampled low at edge N: Pwm_En, OP_Rly_C and OP_Scr_C are 0 after edge N+1 (1-cycle latency).
- Run_Req rising sampled at edge N: Scr=1 after N+1. Rly=1 at N+1+SCR_LEAD_CYC. Pwm_En=1 at N+1+SCR_LEAD_CYC+RLY_SETTLE_CYC.
- Run_Req falling in RUN: Pwm_En=0 and Rly=0 one cycle later, Scr=1 in the same cycle. Scr=0 SCR_HOLD_CYC later.
- Reset_D edge detection uses a 1-register history: the clear takes effect 1 cycle after the rising edge is sampled. Reset_D held high does not retrigger.
- Synchronous Rst asserted mid-sequence forces OFF and all outputs to 0 on the next edge.

## Configuration
- INV_SEQ_RETRY_EN defined: auto-retry as described above.
- INV_SEQ_RETRY_EN undefined: any fault goes directly to LOCKOUT. RETRY_CYC, RETRY_CLR_CYC and MAX_RETRY are ignored. Retry_Cnt still counts faults and saturates at 7, but never gates behaviour.

## Structure
- Package inv_seq_pkg holds the state encoding (OFF=0, SCR_LEAD=1, RLY_SETTLE=2, RUN=3, STOP=4, FAULT=5, LOCKOUT=6) and the Fault_Code bit indices.
- Sub-module inv_seq_timer: a loadable CNT_W down-counter with a load input and a done output.

## Test plan
All scenarios use SCR_LEAD_CYC=4, RLY_SETTLE_CYC=8, SCR_HOLD_CYC=3, RETRY_CYC=10, RETRY_CLR_CYC=20, MAX_RETRY=3.
- Start: Run_Req rises at cycle 0 -> Scr=1 at 1, Rly=1 at 5, Pwm_En=1 and Scr=0 at 13.
- Stop: Run_Req falls in RUN at cycle 50 -> Pwm_En=0, Rly=0, Scr=1 at 51; Scr=0 and State=OFF at 54.
- Retry: InvOcp_F pulses low 1 cycle in RUN -> drives 0 next cycle, Fault_Code=3'b001, Retry_Cnt=1; SCR_LEAD re-entered 10 cycles later.
- Lockout: three faults without 20 cycles of RUN in between -> Lockout=1, drives stay 0 with Run_Req=1. A Reset_D rising edge -> OFF, Fault_Code=0, Retry_Cnt=0.
- Simultaneous events: BusOvp_F and OP_Ovp_F low in the same cycle as a Reset_D edge -> Fault_Code=3'b110, Retry_Cnt=1.
- Reset and config: Rst asserted during RLY_SETTLE -> all outputs 0 next edge. With INV_SEQ_RETRY_EN undefined, the first fault -> Lockout=1.

Source files
------------

// File: rtl/inv_seq_pkg.sv
// inv_seq_pkg: state encoding and fault-code bit positions for the output sequencer
package inv_seq_pkg;
  typedef enum logic [2:0] {
    ST_OFF        = 3'd0,
    ST_SCR_LEAD   = 3'd1,
    ST_RLY_SETTLE = 3'd2,
    ST_RUN        = 3'd3,
    ST_STOP       = 3'd4,
    ST_FAULT      = 3'd5,
    ST_LOCKOUT    = 3'd6
  } state_t;
  localparam int FC_OCP    = 0;
  localparam int FC_OVP    = 1;
  localparam int FC_BUSOVP = 2;
endpackage

// File: rtl/inv_seq_if.sv
// inv_seq_if: DSP commands, protection flags and bridge drive/status of one output channel
interface inv_seq_if;
  logic       Run_Req;
  logic       Reset_D;
  logic       InvOcp_F;
  logic       OP_Ovp_F;
  logic       BusOvp_F;
  logic       Pwm_En;
  logic       OP_Rly_C;
  logic       OP_Scr_C;
  logic [2:0] Fault_Code;
  logic [2:0] Retry_Cnt;
  logic       Lockout;
  logic [2:0] State;
  modport master (
    output Run_Req, Reset_D, InvOcp_F, OP_Ovp_F, BusOvp_F,
    input  Pwm_En, OP_Rly_C, OP_Scr_C, Fault_Code, Retry_Cnt, Lockout, State
  );
  modport slave (
    input  Run_Req, Reset_D, InvOcp_F, OP_Ovp_F, BusOvp_F,
    output Pwm_En, OP_Rly_C, OP_Scr_C, Fault_Code, Retry_Cnt, Lockout, State
  );
endinterface

// File: rtl/inv_seq_timer.sv
// inv_seq_timer: loadable down-counter that parks at zero and flags done there
module inv_seq_timer #(
  parameter int CNT_W = 26
) (
  input  logic             CLK_50M,
  input  logic             Rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             done
);
  logic [CNT_W-1:0] cnt;
  always_ff @(posedge CLK_50M)
    if (Rst) cnt <= '0;
    else if (load) cnt <= load_val;
    else if (cnt != '0) cnt <= cnt - 1'b1;
  assign done = cnt == '0;
endmodule

// File: rtl/inv_output_sequencer.sv
// inv_output_sequencer: SCR/relay/PWM start-stop ordering with fault kill and retry/lockout
// Define INV_SEQ_RETRY_EN for bounded auto-retry; otherwise every fault locks out.
module inv_output_sequencer
  import inv_seq_pkg::*;
#(
  parameter int SCR_LEAD_CYC   = 50000,
  parameter int RLY_SETTLE_CYC = 500000,
  parameter int SCR_HOLD_CYC   = 250000,
  parameter int RETRY_CYC      = 5000000,
  parameter int RETRY_CLR_CYC  = 50000000,
  parameter int MAX_RETRY      = 3,
  parameter int CNT_W          = 26
) (
  input logic      CLK_50M,
  input logic      Rst,
  inv_seq_if.slave io
);
  state_t           st, nxt, fault_dest;
  logic             rd_q, rd_edge, flt, done, active, fault_entry, clr;
  logic [2:0]       fvec, cnt_base, cnt_inc;
  logic [CNT_W-1:0] load_val, run_ld;
  assign rd_edge     = io.Reset_D & ~rd_q;
  assign flt         = |fvec;
  assign active      = st inside {ST_SCR_LEAD, ST_RLY_SETTLE, ST_RUN, ST_STOP};
  assign fault_entry = active & flt;
  assign cnt_base    = rd_edge ? 3'd0 : io.Retry_Cnt;
  assign cnt_inc     = cnt_base == 3'd7 ? 3'd7 : cnt_base + 3'd1;
  assign io.State    = st;
`ifdef INV_SEQ_RETRY_EN
  assign fault_dest = cnt_inc >= 3'(MAX_RETRY) ? ST_LOCKOUT : ST_FAULT;
  assign clr        = st == ST_RUN && done;
  assign run_ld     = CNT_W'(RETRY_CLR_CYC - 1);
`else
  logic unused_cfg;
  assign unused_cfg = ^{RETRY_CLR_CYC, MAX_RETRY};
  assign fault_dest = ST_LOCKOUT;
  assign clr        = 1'b0;
  assign run_ld     = '0;
`endif
  always_comb begin
    fvec            = '0;
    fvec[FC_OCP]    = ~io.InvOcp_F;
    fvec[FC_OVP]    = ~io.OP_Ovp_F;
    fvec[FC_BUSOVP] = ~io.BusOvp_F;
  end
  always_comb begin
    nxt = st;
    case (st)
      ST_OFF:        nxt = io.Run_Req && !flt ? ST_SCR_LEAD : ST_OFF;
      ST_SCR_LEAD:   nxt = done ? ST_RLY_SETTLE : st;
      ST_RLY_SETTLE: nxt = done ? ST_RUN : st;
      ST_STOP:       nxt = done ? ST_OFF : st;
      ST_FAULT:      nxt = !done ? st : io.Run_Req && !flt ? ST_SCR_LEAD : ST_OFF;
      ST_LOCKOUT:    nxt = rd_edge ? ST_OFF : st;
      default:       nxt = st;
    endcase
    if (active && st != ST_STOP && !io.Run_Req) nxt = ST_STOP;
    if (fault_entry) nxt = fault_dest;
  end
  // every state change reloads the shared timer with the new state's duration minus one
  always_comb
    load_val = nxt == ST_SCR_LEAD   ? CNT_W'(SCR_LEAD_CYC - 1)   :
               nxt == ST_RLY_SETTLE ? CNT_W'(RLY_SETTLE_CYC - 1) :
               nxt == ST_RUN        ? run_ld                     :
               nxt == ST_STOP       ? CNT_W'(SCR_HOLD_CYC - 1)   :
               nxt == ST_FAULT      ? CNT_W'(RETRY_CYC - 1)      : '0;
  inv_seq_timer #(.CNT_W(CNT_W)) u_timer (
    .CLK_50M  (CLK_50M),
    .Rst      (Rst),
    .load     (nxt != st),
    .load_val (load_val),
    .done     (done)
  );
  // drives decode the next state so they change together with the state register
  always_ff @(posedge CLK_50M)
    if (Rst) begin
      st            <= ST_OFF;
      rd_q          <= 1'b0;
      io.Pwm_En     <= 1'b0;
      io.OP_Rly_C   <= 1'b0;
      io.OP_Scr_C   <= 1'b0;
      io.Lockout    <= 1'b0;
      io.Fault_Code <= '0;
      io.Retry_Cnt  <= '0;
    end else begin
      st            <= nxt;
      rd_q          <= io.Reset_D;
      io.Pwm_En     <= nxt == ST_RUN;
      io.OP_Rly_C   <= nxt inside {ST_RLY_SETTLE, ST_RUN};
      io.OP_Scr_C   <= nxt inside {ST_SCR_LEAD, ST_RLY_SETTLE, ST_STOP};
      io.Lockout    <= nxt == ST_LOCKOUT;
      io.Fault_Code <= fault_entry ? fvec : rd_edge ? 3'd0 : io.Fault_Code;
      io.Retry_Cnt  <= fault_entry ? cnt_inc : clr ? 3'd0 : cnt_base;
    end
endmodule

// File: tb/tb_inv_output_sequencer.sv
// tb_inv_output_sequencer: directed scenarios plus random stimulus against a cycle-level reference model
module tb_inv_output_sequencer;
`ifdef INV_SEQ_RETRY_EN
  localparam bit RETRY_EN = 1'b1;
`else
  localparam bit RETRY_EN = 1'b0;
`endif
  localparam int LEAD = 4, SETTLE = 8, HOLD = 3, RETRY = 10, CLR = 20, MAX = 3;
  localparam int S_OFF = 0, S_LEAD = 1, S_SETTLE = 2, S_RUN = 3, S_STOP = 4, S_FAULT = 5, S_LOCK = 6;
  logic clk = 1'b0;
  logic rst;
  int   n_chk = 0, n_fail = 0;
  int   m_st, m_age, m_code, m_cnt;
  bit   m_prev;
  inv_seq_if bus ();
  inv_output_sequencer #(
    .SCR_LEAD_CYC(LEAD), .RLY_SETTLE_CYC(SETTLE), .SCR_HOLD_CYC(HOLD),
    .RETRY_CYC(RETRY), .RETRY_CLR_CYC(CLR), .MAX_RETRY(MAX), .CNT_W(8)
  ) dut (
    .CLK_50M (clk),
    .Rst     (rst),
    .io      (bus)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
    end
  endtask
  function automatic int dur(input int s);
    case (s)
      S_LEAD:   return LEAD;
      S_SETTLE: return SETTLE;
      S_RUN:    return CLR;
      S_STOP:   return HOLD;
      S_FAULT:  return RETRY;
      default:  return 1;
    endcase
  endfunction
  // reference: m_age counts whole cycles spent in the current state, 0 on the entry cycle
  task automatic model_step();
    bit edge_d, flt, up;
    int n, ns;
    if (rst) begin
      m_st = S_OFF; m_age = 0; m_code = 0; m_cnt = 0; m_prev = 1'b0;
      return;
    end
    edge_d = bus.Reset_D && !m_prev;
    m_prev = bus.Reset_D;
    flt = !(bus.InvOcp_F && bus.OP_Ovp_F && bus.BusOvp_F);
    up = m_age >= dur(m_st) - 1;
    ns = m_st;
    if (m_st >= S_LEAD && m_st <= S_STOP && flt) begin
      n = edge_d ? 0 : m_cnt;
      n = n + 1 > 7 ? 7 : n + 1;
      m_cnt = n;
      m_code = {!bus.BusOvp_F, !bus.OP_Ovp_F, !bus.InvOcp_F};
      ns = (RETRY_EN && n < MAX) ? S_FAULT : S_LOCK;
    end else begin
      if (edge_d) begin m_code = 0; m_cnt = 0; end
      case (m_st)
        S_OFF:    if (bus.Run_Req && !flt) ns = S_LEAD;
        S_LEAD:   ns = !bus.Run_Req ? S_STOP : up ? S_SETTLE : S_LEAD;
        S_SETTLE: ns = !bus.Run_Req ? S_STOP : up ? S_RUN : S_SETTLE;
        S_RUN: begin
          if (!bus.Run_Req) ns = S_STOP;
          if (RETRY_EN && up) m_cnt = 0;
        end
        S_STOP:   if (up) ns = S_OFF;
        S_FAULT:  if (up) ns = (bus.Run_Req && !flt) ? S_LEAD : S_OFF;
        S_LOCK:   if (edge_d) ns = S_OFF;
        default:  ns = S_OFF;
      endcase
    end
    m_age = ns != m_st ? 0 : m_age + 1;
    m_st = ns;
  endtask
  task automatic tick();
    model_step();
    @(negedge clk);
    check("drives", {bus.Pwm_En, bus.OP_Rly_C, bus.OP_Scr_C},
          {m_st == S_RUN, m_st == S_SETTLE || m_st == S_RUN,
           m_st == S_LEAD || m_st == S_SETTLE || m_st == S_STOP});
    check("state", bus.State, m_st);
    check("fault_code", bus.Fault_Code, m_code);
    check("retry_cnt", bus.Retry_Cnt, m_cnt);
    check("lockout", bus.Lockout, m_st == S_LOCK);
  endtask
  task automatic wait_model(input int s);
    for (int k = 0; k < 60 && m_st != s; k++) tick();
  endtask
  initial begin
    int t_scr, t_rly, t_pwm;
    rst = 1'b1;
    bus.Run_Req = 1'b0; bus.Reset_D = 1'b0;
    bus.InvOcp_F = 1'b1; bus.OP_Ovp_F = 1'b1; bus.BusOvp_F = 1'b1;
    repeat (3) tick();
    check("rst_out", {bus.Pwm_En, bus.OP_Rly_C, bus.OP_Scr_C, bus.Lockout,
                      bus.Fault_Code, bus.Retry_Cnt, bus.State}, 0);
    rst = 1'b0;
    repeat (2) tick();
    t_scr = -1; t_rly = -1; t_pwm = -1;
    bus.Run_Req = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      tick();
      if (bus.OP_Scr_C && t_scr < 0) t_scr = i;
      if (bus.OP_Rly_C && t_rly < 0) t_rly = i;
      if (bus.Pwm_En && t_pwm < 0) t_pwm = i;
    end
    check("t_scr", t_scr, 1);
    check("t_rly", t_rly, 5);
    check("t_pwm", t_pwm, 13);
    repeat (30) tick();
    bus.Run_Req = 1'b0;
    tick();
    check("stop_drv", {bus.Pwm_En, bus.OP_Rly_C, bus.OP_Scr_C}, 3'b001);
    repeat (3) tick();
    check("stop_off", {bus.State, bus.OP_Scr_C}, 0);
    bus.Run_Req = 1'b1;
    wait_model(S_RUN);
    repeat (2) tick();
    bus.InvOcp_F = 1'b0;
    tick();
    bus.InvOcp_F = 1'b1;
    check("ocp_drv", {bus.Pwm_En, bus.OP_Rly_C, bus.OP_Scr_C}, 0);
    check("ocp_code", bus.Fault_Code, 1);
    check("ocp_cnt", bus.Retry_Cnt, 1);
    repeat (12) tick();
    if (!RETRY_EN) begin
      bus.Reset_D = 1'b1; tick(); bus.Reset_D = 1'b0; tick();
    end
    for (int f = 0; f < MAX; f++) begin
      wait_model(S_RUN);
      bus.OP_Ovp_F = 1'b0;
      tick();
      bus.OP_Ovp_F = 1'b1;
    end
    repeat (15) tick();
    check("lock_hold", {bus.Lockout, bus.Pwm_En, bus.OP_Rly_C, bus.OP_Scr_C}, 4'b1000);
    bus.Reset_D = 1'b1;
    tick();
    check("unlock", {bus.Lockout, bus.State, bus.Fault_Code, bus.Retry_Cnt}, 0);
    bus.Reset_D = 1'b0;
    wait_model(S_RUN);
    tick();
    bus.BusOvp_F = 1'b0; bus.OP_Ovp_F = 1'b0; bus.Reset_D = 1'b1;
    tick();
    bus.BusOvp_F = 1'b1; bus.OP_Ovp_F = 1'b1; bus.Reset_D = 1'b0;
    check("simul_code", bus.Fault_Code, 6);
    check("simul_cnt", bus.Retry_Cnt, 1);
    check("cfg_lock", bus.Lockout, RETRY_EN ? 0 : 1);
    tick();
    bus.Reset_D = 1'b1; tick(); bus.Reset_D = 1'b0;
    wait_model(S_SETTLE);
    repeat (2) tick();
    rst = 1'b1;
    tick();
    check("rst_mid", {bus.Pwm_En, bus.OP_Rly_C, bus.OP_Scr_C, bus.Lockout,
                      bus.Fault_Code, bus.Retry_Cnt, bus.State}, 0);
    rst = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(29) == 0) bus.Run_Req = ~bus.Run_Req;
      if ($urandom_range(19) == 0) bus.Reset_D = ~bus.Reset_D;
      bus.InvOcp_F = $urandom_range(79) != 0;
      bus.OP_Ovp_F = $urandom_range(79) != 0;
      bus.BusOvp_F = $urandom_range(79) != 0;
      rst = $urandom_range(399) == 0;
      tick();
    end
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
